// File: rtl/multi_mode_ff_reg.sv
// Bank of WIDTH independent flip-flops selectable as SR, JK, D or T per cycle,
// with illegal SR-event detection (pulse, sticky flag, saturating counter).
module multi_mode_ff_reg #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               SR_BOTH   = 0,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             err_pulse,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [1:0] MODE_SR = 2'b00;
    localparam logic [1:0] MODE_JK = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    localparam logic [1:0] SRB_HOLD = 2'd0;
    localparam logic [1:0] SRB_SET  = 2'd1;
    localparam logic [1:0] SRB_CLR  = 2'd2;

    // Out-of-range SR_BOTH values collapse to hold.
    localparam logic [1:0] SR_BOTH_EFF = (SR_BOTH == 1) ? SRB_SET :
                                         (SR_BOTH == 2) ? SRB_CLR : SRB_HOLD;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    function automatic logic next_bit(
        input logic [1:0] m,
        input logic       cur,
        input logic       ai,
        input logic       bi
    );
        logic nxt;
        nxt = cur;
        case (m)
            MODE_SR: begin
                case ({ai, bi})
                    2'b10:   nxt = 1'b1;
                    2'b01:   nxt = 1'b0;
                    2'b11: begin
                        case (SR_BOTH_EFF)
                            SRB_SET: nxt = 1'b1;
                            SRB_CLR: nxt = 1'b0;
                            default: nxt = cur;
                        endcase
                    end
                    default: nxt = cur;
                endcase
            end
            MODE_JK: begin
                case ({ai, bi})
                    2'b10:   nxt = 1'b1;
                    2'b01:   nxt = 1'b0;
                    2'b11:   nxt = ~cur;
                    default: nxt = cur;
                endcase
            end
            MODE_D:  nxt = ai;
            MODE_T:  nxt = ai ? ~cur : cur;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] qb_r;
    logic             err_pulse_r;
    logic             err_r;
    logic [CNT_W-1:0] err_cnt_r;

    logic [WIDTH-1:0] q_mode_s;
    logic [WIDTH-1:0] q_next_s;
    logic             illegal_s;
    logic [CNT_W-1:0] cnt_base_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             err_next_s;

    // Per-bit next state for the mode presented on this edge.
    always_comb begin
        q_mode_s = q_r;
        for (int i = 0; i < WIDTH; i++) begin
            q_mode_s[i] = next_bit(mode, q_r[i], a[i], b[i]);
        end
        if (en) begin
            q_next_s = q_mode_s;
        end else begin
            q_next_s = q_r;
        end
    end

    // Illegal-event detection and error bookkeeping: clear is applied before counting.
    always_comb begin
        illegal_s = en & (mode == MODE_SR) & (|(a & b));
        if (clr_err) begin
            cnt_base_s = CNT_ZERO;
        end else begin
            cnt_base_s = err_cnt_r;
        end
        if (illegal_s) begin
            err_next_s = 1'b1;
            if (cnt_base_s == CNT_MAX) begin
                cnt_next_s = cnt_base_s;
            end else begin
                cnt_next_s = cnt_base_s + CNT_ONE;
            end
        end else begin
            err_next_s = clr_err ? 1'b0 : err_r;
            cnt_next_s = cnt_base_s;
        end
    end

    // State registers; qb is registered alongside q so it is never a cycle behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r         <= RESET_VAL;
            qb_r        <= ~RESET_VAL;
            err_pulse_r <= 1'b0;
            err_r       <= 1'b0;
            err_cnt_r   <= CNT_ZERO;
        end else begin
            q_r         <= q_next_s;
            qb_r        <= ~q_next_s;
            err_pulse_r <= illegal_s;
            err_r       <= err_next_s;
            err_cnt_r   <= cnt_next_s;
        end
    end

    assign q         = q_r;
    assign qb        = qb_r;
    assign err_pulse = err_pulse_r;
    assign err       = err_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_multi_mode_ff_reg.sv
// Self-checking bench: directed vector table on a CNT_W=2 instance plus random
// stimulus on four parameter variants checked against a behavioural model.
module tb_multi_mode_ff_reg;

    logic       clk = 1'b0;
    logic       rst, en, clr_err;
    logic [1:0] mode;
    logic [3:0] a, b;

    logic [3:0] q0, qb0, q1, qb1, q2, qb2, q3, qb3;
    logic       p0, p1, p2, p3, e0, e1, e2, e3;
    logic [1:0] c0;
    logic [7:0] c1;
    logic [2:0] c2, c3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multi_mode_ff_reg #(.WIDTH(4), .RESET_VAL(4'b0000), .SR_BOTH(0), .CNT_W(2)) u0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
        .q(q0), .qb(qb0), .err_pulse(p0), .err(e0), .err_cnt(c0));
    multi_mode_ff_reg #(.WIDTH(4), .RESET_VAL(4'b1001), .SR_BOTH(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
        .q(q1), .qb(qb1), .err_pulse(p1), .err(e1), .err_cnt(c1));
    multi_mode_ff_reg #(.WIDTH(4), .RESET_VAL(4'b0110), .SR_BOTH(2), .CNT_W(3)) u2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
        .q(q2), .qb(qb2), .err_pulse(p2), .err(e2), .err_cnt(c2));
    multi_mode_ff_reg #(.WIDTH(4), .RESET_VAL(4'b1111), .SR_BOTH(3), .CNT_W(3)) u3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
        .q(q3), .qb(qb3), .err_pulse(p3), .err(e3), .err_cnt(c3));

    logic [3:0] q_a [4];
    logic [3:0] qb_a[4];
    logic       p_a [4];
    logic       e_a [4];
    logic [7:0] c_a [4];

    assign q_a[0] = q0;  assign qb_a[0] = qb0; assign p_a[0] = p0; assign e_a[0] = e0;
    assign q_a[1] = q1;  assign qb_a[1] = qb1; assign p_a[1] = p1; assign e_a[1] = e1;
    assign q_a[2] = q2;  assign qb_a[2] = qb2; assign p_a[2] = p2; assign e_a[2] = e2;
    assign q_a[3] = q3;  assign qb_a[3] = qb3; assign p_a[3] = p3; assign e_a[3] = e3;
    assign c_a[0] = {6'b000000, c0};
    assign c_a[1] = c1;
    assign c_a[2] = {5'b00000, c2};
    assign c_a[3] = {5'b00000, c3};

    // Reference model state, one entry per instance.
    int         sr_p[4] = '{0, 1, 2, 3};
    int         cmax[4] = '{3, 255, 7, 7};
    logic [3:0] rv  [4] = '{4'b0000, 4'b1001, 4'b0110, 4'b1111};
    logic [3:0] mq  [4];
    logic       merr[4];
    logic       mpul[4];
    int         mcnt[4];

    function automatic logic ref_bit(input int m, input int srb, input logic cur,
                                     input logic s, input logic r);
        if (m == 2) return s;
        if (m == 3) return s ? !cur : cur;
        if (s && !r) return 1'b1;
        if (!s && r) return 1'b0;
        if (!s && !r) return cur;
        if (m == 1) return !cur;
        if (srb == 1) return 1'b1;
        if (srb == 2) return 1'b0;
        return cur;
    endfunction

    task automatic model_step();
        logic ill;
        ill = en && (mode == 2'b00) && ((a & b) != 4'b0000);
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                mq[k] = rv[k]; merr[k] = 1'b0; mcnt[k] = 0; mpul[k] = 1'b0;
            end else begin
                if (en) begin
                    for (int i = 0; i < 4; i++)
                        mq[k][i] = ref_bit(int'(mode), sr_p[k], mq[k][i], a[i], b[i]);
                end
                mpul[k] = ill;
                if (clr_err) begin merr[k] = 1'b0; mcnt[k] = 0; end
                if (ill) begin
                    merr[k] = 1'b1;
                    if (mcnt[k] < cmax[k]) mcnt[k] = mcnt[k] + 1;
                end
            end
        end
    endtask

    task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d got=%0h want=%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 4; k++) begin
            chk("q",         k, {4'b0000, q_a[k]},  {4'b0000, mq[k]});
            chk("qb",        k, {4'b0000, qb_a[k]}, {4'b0000, ~mq[k]});
            chk("err_pulse", k, {7'b0, p_a[k]},     {7'b0, mpul[k]});
            chk("err",       k, {7'b0, e_a[k]},     {7'b0, merr[k]});
            chk("err_cnt",   k, c_a[k],             8'(mcnt[k]));
        end
    endtask

    task automatic step_and_check();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic apply(input logic r, input logic e, input logic [1:0] m,
                         input logic [3:0] av, input logic [3:0] bv, input logic c);
        rst = r; en = e; mode = m; a = av; b = bv; clr_err = c;
        step_and_check();
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic [3:0] a;
        logic [3:0] b;
        logic       clr;
        logic [3:0] eq;
        logic       ep;
        logic       ee;
        logic [1:0] ec;
    } vec_t;

    vec_t tbl[18];

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; a = 4'b0000; b = 4'b0000; clr_err = 1'b0;

        //           rst   en    mode   a        b        clr   q        pul   err   cnt
        tbl[0]  = '{1'b1, 1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 1'b1, 2'b00, 4'b0011, 4'b1100, 1'b0, 4'b0011, 1'b0, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 1'b1, 2'b01, 4'b1111, 4'b1111, 1'b0, 4'b1100, 1'b0, 1'b0, 2'd0};
        tbl[3]  = '{1'b0, 1'b1, 2'b01, 4'b1111, 4'b1111, 1'b0, 4'b0011, 1'b0, 1'b0, 2'd0};
        tbl[4]  = '{1'b0, 1'b1, 2'b10, 4'b1010, 4'b0000, 1'b0, 4'b1010, 1'b0, 1'b0, 2'd0};
        tbl[5]  = '{1'b0, 1'b1, 2'b11, 4'b0110, 4'b0000, 1'b0, 4'b1100, 1'b0, 1'b0, 2'd0};
        tbl[6]  = '{1'b0, 1'b0, 2'b10, 4'b1111, 4'b0000, 1'b0, 4'b1100, 1'b0, 1'b0, 2'd0};
        tbl[7]  = '{1'b0, 1'b1, 2'b00, 4'b0101, 4'b0101, 1'b0, 4'b1100, 1'b1, 1'b1, 2'd1};
        tbl[8]  = '{1'b0, 1'b1, 2'b00, 4'b0101, 4'b0101, 1'b0, 4'b1100, 1'b1, 1'b1, 2'd2};
        tbl[9]  = '{1'b0, 1'b1, 2'b00, 4'b0101, 4'b0101, 1'b0, 4'b1100, 1'b1, 1'b1, 2'd3};
        tbl[10] = '{1'b0, 1'b1, 2'b00, 4'b0101, 4'b0101, 1'b0, 4'b1100, 1'b1, 1'b1, 2'd3};
        tbl[11] = '{1'b0, 1'b1, 2'b00, 4'b0101, 4'b0101, 1'b0, 4'b1100, 1'b1, 1'b1, 2'd3};
        tbl[12] = '{1'b0, 1'b1, 2'b10, 4'b1100, 4'b1111, 1'b0, 4'b1100, 1'b0, 1'b1, 2'd3};
        tbl[13] = '{1'b0, 1'b1, 2'b00, 4'b0101, 4'b0101, 1'b1, 4'b1100, 1'b1, 1'b1, 2'd1};
        tbl[14] = '{1'b0, 1'b0, 2'b00, 4'b0101, 4'b0101, 1'b1, 4'b1100, 1'b0, 1'b0, 2'd0};
        tbl[15] = '{1'b0, 1'b1, 2'b01, 4'b1111, 4'b1111, 1'b0, 4'b0011, 1'b0, 1'b0, 2'd0};
        tbl[16] = '{1'b1, 1'b1, 2'b01, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0};
        tbl[17] = '{1'b0, 1'b1, 2'b01, 4'b1111, 4'b1111, 1'b0, 4'b1111, 1'b0, 1'b0, 2'd0};

        @(negedge clk);
        for (int v = 0; v < 18; v++) begin
            apply(tbl[v].rst, tbl[v].en, tbl[v].mode, tbl[v].a, tbl[v].b, tbl[v].clr);
            chk("tbl_q",     v, {4'b0000, q0},  {4'b0000, tbl[v].eq});
            chk("tbl_qb",    v, {4'b0000, qb0}, {4'b0000, ~tbl[v].eq});
            chk("tbl_pulse", v, {7'b0, p0},     {7'b0, tbl[v].ep});
            chk("tbl_err",   v, {7'b0, e0},     {7'b0, tbl[v].ee});
            chk("tbl_cnt",   v, {6'b0, c0},     {6'b0, tbl[v].ec});
        end

        // Reset raised mid-burst: nothing moves until the next edge.
        apply(1'b0, 1'b1, 2'b00, 4'b1111, 4'b1111, 1'b0);
        apply(1'b0, 1'b1, 2'b01, 4'b1111, 4'b1111, 1'b0);
        apply(1'b0, 1'b1, 2'b01, 4'b1111, 4'b1111, 1'b0);
        rst = 1'b1;
        #3;
        check_model();
        chk("pre_rst_cnt", 0, {6'b0, c0}, 8'd1);
        step_and_check();
        chk("rst_q0",   0, {4'b0000, q0}, 8'h00);
        chk("rst_q1",   1, {4'b0000, q1}, 8'h09);
        chk("rst_qb1",  1, {4'b0000, qb1}, 8'h06);
        chk("rst_cnt0", 0, {6'b0, c0}, 8'd0);
        chk("rst_err0", 0, {7'b0, e0}, 8'd0);
        apply(1'b0, 1'b1, 2'b01, 4'b1111, 4'b1111, 1'b0);
        chk("post_rst_q1", 1, {4'b0000, q1}, 8'h06);

        // Randomised run against the model.
        for (int n = 0; n < 600; n++) begin
            apply(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                  2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_mode_ff_reg.md
MULTI_MODE_FF_REG -- requirements
Module: multi_mode_ff_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning number of independent flip-flop bits.
REQ-002 The block SHALL have parameter RESET_VAL, default all-zeros, meaning the q value loaded on reset.
REQ-003 The block SHALL have parameter SR_BOTH, default 0, meaning the SR-mode s=r=1 response: 0 hold, 1 force 1, 2 force 0.
REQ-004 The block SHALL have parameter CNT_W, default 8, meaning the width of the illegal-event counter.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port en, input, 1 bit: update enable.
REQ-008 The block SHALL have port mode, input, 2 bits: 00 SR, 01 JK, 10 D, 11 T.
REQ-009 The block SHALL have port a, input, WIDTH bits: per-bit s / j / d / t, depending on mode.
REQ-010 The block SHALL have port b, input, WIDTH bits: per-bit r / k; ignored in D and T modes.
REQ-011 The block SHALL have port clr_err, input, 1 bit: clears err and err_cnt.
REQ-012 The block SHALL have port q, output, WIDTH bits: register state.
REQ-013 The block SHALL have port qb, output, WIDTH bits: complement of q.
REQ-014 The block SHALL have port err_pulse, output, 1 bit: registered one-cycle flag for an illegal SR event on the previous edge.
REQ-015 The block SHALL have port err, output, 1 bit: sticky illegal-event flag.
REQ-016 The block SHALL have port err_cnt, output, CNT_W bits: saturating count of illegal-event cycles.

Function
REQ-017 The block SHALL update each q[i] independently on every rising clk edge with en=1, using the mode sampled on that same edge (no extra latency).
REQ-018 The block SHALL hold q, err and err_cnt when en=0, and SHALL drive err_pulse 0 on that edge; clr_err still applies.
REQ-019 SR mode SHALL behave as follows per bit: a=1,b=0 -> 1; a=0,b=1 -> 0; a=0,b=0 -> hold; a=1,b=1 -> per SR_BOTH.
REQ-020 JK mode SHALL behave as follows per bit: 10 -> 1; 01 -> 0; 00 -> hold; 11 -> toggle.
REQ-021 D mode SHALL load q[i] = a[i].
REQ-022 T mode SHALL toggle q[i] when a[i]=1 and hold it when a[i]=0.
REQ-023 qb SHALL equal ~q at all times, including during and after reset.
REQ-024 An illegal event SHALL be defined as en=1, mode=00, and at least one bit with a=b=1; it SHALL count once per cycle regardless of how many bits are illegal.
REQ-025 On an illegal event, err_pulse SHALL be 1 for exactly the following cycle, err SHALL be set to 1, and err_cnt SHALL increment by 1, saturating at 2^CNT_W-1 with no wrap-around.
REQ-026 clr_err=1 without an illegal event SHALL set err=0 and err_cnt=0 on the edge.
REQ-027 clr_err=1 together with an illegal event SHALL leave err=1 and err_cnt=1 (clear first, then count).
REQ-028 SR_BOTH values outside 0..2 SHALL behave as 0 (hold).

Reset
REQ-029 rst=1 at a rising edge SHALL set q=RESET_VAL, qb=~RESET_VAL, err=0, err_pulse=0 and err_cnt=0, overriding en, mode, a, b and clr_err.
REQ-030 Reset asserted mid-operation SHALL take effect on the next edge only, with no asynchronous output change, and normal operation SHALL resume on the first edge with rst=0.

Verification
REQ-031 Reset and SR mode: rst=1 for one edge, then en=1, mode=00, a=0011, b=1100 -> q=0011, qb=1100, err=0.
REQ-032 JK toggle: q=0011, mode=01, a=b=1111 for 2 edges -> q=1100, then q=0011.
REQ-033 D/T/enable: mode=10, a=1010 -> q=1010; mode=11, a=0110 -> q=1100; en=0 with a=1111 -> q stays 1100.
REQ-034 Illegal SR (SR_BOTH=0): q=1100, mode=00, a=b=0101 -> q=1100, err_pulse=1 for one cycle, err=1, err_cnt=1; repeat 2 more edges -> err_cnt=3.
REQ-035 Saturation and clear (CNT_W=2): 5 consecutive illegal edges -> err_cnt=3; clr_err with an illegal event -> err_cnt=1, err=1; clr_err alone -> err_cnt=0, err=0.
REQ-036 Reset mid-operation: rst=1 during a JK toggle burst -> next edge q=RESET_VAL and err_cnt=0; no change before that edge.
